// File: rtl/thinkgear_parser.sv
// ThinkGear packet parser: locks onto AA AA, validates PLEN, rows and checksum,
// and commits ATTENTION / MEDITATION / POOR_SIGNAL from good packets only.
module thinkgear_parser #(
    parameter int unsigned TIMEOUT_CYC  = 200_000_000,
    parameter int unsigned TO_W         = 28,
    parameter int unsigned MAX_PLEN     = 169,
    parameter logic [7:0]  POOR_DEFAULT = 8'd200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] attention_data,
    output logic [7:0] meditation_data,
    output logic [7:0] signal_data,
    output logic       link_up,
    output logic       pkt_ok,
    output logic       pkt_err
);
    localparam logic [7:0]      SYNC_BYTE   = 8'hAA;
    localparam logic [7:0]      EXCODE_BYTE = 8'h55;
    localparam logic [7:0]      MAX_PLEN_B  = 8'(MAX_PLEN);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_SYNC1,
        S_SYNC2,
        S_PLEN,
        S_CODE,
        S_VLEN,
        S_VALUE,
        S_SKIP,
        S_CSUM
    } state_t;

    state_t          state_reg;
    logic [7:0]      sum_reg;
    logic [7:0]      count_reg;
    logic [7:0]      vlen_reg;
    logic [7:0]      code_reg;
    logic [7:0]      excode_reg;
    logic            single_reg;
    logic            malformed_reg;
    logic            link_reg;
    logic            ok_reg;
    logic            err_reg;
    logic [TO_W-1:0] to_cnt_reg;

    logic [7:0] sum_next;
    logic [7:0] count_next;
    logic       csum_match;
    logic       csum_good;
    logic       csum_bad;
    logic       plen_bad;
    logic       pkt_start;
    logic       value_capture;
    logic       timeout_hit;

    assign sum_next      = sum_reg + rx_data;
    assign count_next    = count_reg - 8'd1;
    assign csum_match    = (rx_data == ~sum_reg) && !malformed_reg;
    assign csum_good     = rx_valid && (state_reg == S_CSUM) && csum_match;
    assign csum_bad      = rx_valid && (state_reg == S_CSUM) && !csum_match;
    assign plen_bad      = rx_valid && (state_reg == S_PLEN) && (rx_data != SYNC_BYTE)
                           && (rx_data > MAX_PLEN_B);
    assign pkt_start     = rx_valid && (state_reg == S_SYNC2) && (rx_data == SYNC_BYTE);
    // Only a single-byte value row outside any extended-code level is a field we track.
    assign value_capture = rx_valid && (state_reg == S_VALUE) && single_reg && (excode_reg == 8'd0);
    assign timeout_hit   = link_reg && (to_cnt_reg == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_SYNC1;
            sum_reg       <= 8'd0;
            count_reg     <= 8'd0;
            vlen_reg      <= 8'd0;
            code_reg      <= 8'd0;
            excode_reg    <= 8'd0;
            single_reg    <= 1'b0;
            malformed_reg <= 1'b0;
        end else if (rx_valid) begin
            case (state_reg)
                S_SYNC1: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_reg <= S_SYNC2;
                    end
                end
                S_SYNC2: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_reg     <= S_PLEN;
                        sum_reg       <= 8'd0;
                        count_reg     <= 8'd0;
                        excode_reg    <= 8'd0;
                        malformed_reg <= 1'b0;
                    end else begin
                        state_reg <= S_SYNC1;
                    end
                end
                S_PLEN: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_reg <= S_PLEN;
                    end else if (rx_data > MAX_PLEN_B) begin
                        state_reg <= S_SYNC1;
                    end else if (rx_data == 8'd0) begin
                        state_reg <= S_CSUM;
                    end else begin
                        count_reg <= rx_data;
                        sum_reg   <= 8'd0;
                        state_reg <= S_CODE;
                    end
                end
                S_CODE: begin
                    sum_reg   <= sum_next;
                    count_reg <= count_next;
                    code_reg  <= rx_data;
                    if (count_next == 8'd0) begin
                        // A code byte (or excode prefix) cannot end the payload.
                        malformed_reg <= 1'b1;
                        state_reg     <= S_CSUM;
                    end else if (rx_data == EXCODE_BYTE) begin
                        excode_reg <= excode_reg + 8'd1;
                    end else if (rx_data < 8'h80) begin
                        vlen_reg   <= 8'd1;
                        single_reg <= 1'b1;
                        state_reg  <= S_VALUE;
                    end else begin
                        state_reg <= S_VLEN;
                    end
                end
                S_VLEN: begin
                    sum_reg    <= sum_next;
                    count_reg  <= count_next;
                    vlen_reg   <= rx_data;
                    single_reg <= (rx_data == 8'd1);
                    if (count_next == 8'd0) begin
                        malformed_reg <= 1'b1;
                        state_reg     <= S_CSUM;
                    end else if ((rx_data == 8'd0) || (rx_data > count_next)) begin
                        malformed_reg <= 1'b1;
                        state_reg     <= S_SKIP;
                    end else begin
                        state_reg <= S_VALUE;
                    end
                end
                S_VALUE: begin
                    sum_reg   <= sum_next;
                    count_reg <= count_next;
                    vlen_reg  <= vlen_reg - 8'd1;
                    if (vlen_reg == 8'd1) begin
                        excode_reg <= 8'd0;
                        state_reg  <= (count_next == 8'd0) ? S_CSUM : S_CODE;
                    end else if (count_next == 8'd0) begin
                        malformed_reg <= 1'b1;
                        state_reg     <= S_CSUM;
                    end
                end
                S_SKIP: begin
                    sum_reg   <= sum_next;
                    count_reg <= count_next;
                    if (count_next == 8'd0) begin
                        state_reg <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    state_reg <= S_SYNC1;
                end
                default: begin
                    state_reg <= S_SYNC1;
                end
            endcase
        end
    end

    // Field 0 = POOR_SIGNAL, 1 = ATTENTION, 2 = MEDITATION.
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
        localparam logic [7:0] FCODE  = (gi == 0) ? 8'h02 : ((gi == 1) ? 8'h04 : 8'h05);
        localparam logic [7:0] FRESET = (gi == 0) ? POOR_DEFAULT : 8'd0;

        logic       pend_vld_reg;
        logic [7:0] pend_val_reg;
        logic [7:0] field_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_vld_reg <= 1'b0;
                pend_val_reg <= 8'd0;
                field_reg    <= FRESET;
            end else begin
                if (pkt_start) begin
                    pend_vld_reg <= 1'b0;
                end else if (value_capture && (code_reg == FCODE)) begin
                    pend_vld_reg <= 1'b1;
                    pend_val_reg <= rx_data;
                end
                // A good packet wins over a timeout landing on the same cycle.
                if (csum_good) begin
                    if (pend_vld_reg) begin
                        field_reg <= pend_val_reg;
                    end
                end else if (timeout_hit) begin
                    field_reg <= FRESET;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_reg   <= 1'b0;
            to_cnt_reg <= '0;
            ok_reg     <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            ok_reg  <= csum_good;
            err_reg <= csum_bad || plen_bad;
            if (csum_good) begin
                link_reg   <= 1'b1;
                to_cnt_reg <= '0;
            end else if (timeout_hit) begin
                link_reg   <= 1'b0;
                to_cnt_reg <= '0;
            end else if (link_reg) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
        end
    end

    assign signal_data     = g_field[0].field_reg;
    assign attention_data  = g_field[1].field_reg;
    assign meditation_data = g_field[2].field_reg;
    assign link_up         = link_reg;
    assign pkt_ok          = ok_reg;
    assign pkt_err         = err_reg;

endmodule
